// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and per-state control vectors for the
// pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t INIT     = 3'd0;
    localparam state_t RUN      = 3'd1;
    localparam state_t LU_STALL = 3'd2;
    localparam state_t MD_BUSY  = 3'd3;
    localparam state_t MISS     = 3'd4;
    localparam state_t FLUSH    = 3'd5;

    // {pc_we, ifid_we, ifid_flush, idex_hit, idex_bubble}
    localparam logic [4:0] OUT_INIT  = 5'b00001;
    localparam logic [4:0] OUT_RUN   = 5'b11010;
    localparam logic [4:0] OUT_LU    = 5'b00011;
    localparam logic [4:0] OUT_MD    = 5'b00000;
    localparam logic [4:0] OUT_MISS  = 5'b00000;
    localparam logic [4:0] OUT_FLUSH = 5'b10111;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic [4:0] state_out(input state_t s);
        logic [4:0] o;
        o = OUT_INIT;
        unique case (s)
            INIT:     o = OUT_INIT;
            RUN:      o = OUT_RUN;
            LU_STALL: o = OUT_LU;
            MD_BUSY:  o = OUT_MD;
            MISS:     o = OUT_MISS;
            FLUSH:    o = OUT_FLUSH;
            default:  o = OUT_INIT;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in ID/EX and the
// source registers of the instruction in IF/ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic [4:0] idex_rt,
    input  logic       idex_mem_read,
    output logic       lu_hz
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (idex_rt == ifid_rs);
    assign rt_match = (idex_rt == ifid_rt);

    assign lu_hz = idex_mem_read
                 & (idex_rt != REG_ZERO)
                 & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline front end.
// Optional saturating stall counter enabled by STALL_CNT_EN.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [4:0]             ifid_rs,
    input  logic [4:0]             ifid_rt,
    input  logic [4:0]             idex_rt,
    input  logic                   idex_mem_read,
    input  logic                   muldiv_start,
    input  logic                   cache_ready,
    input  logic                   branch_taken,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   ifid_flush,
    output logic                   idex_hit,
    output logic                   idex_bubble,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int CW = $clog2(MULDIV_LAT) + 1;
    localparam logic [CW-1:0] MD_LOAD = CW'(MULDIV_LAT - 2);

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] md_cnt;
    logic [CW-1:0] md_cnt_d;
    logic          md_hold;
    logic          md_hold_d;
    logic [4:0]    out_q;
    logic          lu_hz;

    load_use_detect u_lu (
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .idex_rt       (idex_rt),
        .idex_mem_read (idex_mem_read),
        .lu_hz         (lu_hz)
    );

    always_comb begin
        state_d   = state;
        md_cnt_d  = md_cnt;
        md_hold_d = md_hold;
        unique case (state)
            INIT: begin
                state_d = RUN;
            end
            RUN, LU_STALL, FLUSH: begin
                md_hold_d = 1'b0;
                if (!cache_ready) begin
                    state_d = MISS;
                end else if (muldiv_start) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_LOAD;
                end else if (branch_taken) begin
                    state_d = FLUSH;
                end else if (lu_hz && state != LU_STALL) begin
                    state_d = LU_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            MD_BUSY: begin
                // A busy cycle cut short by a miss still counts as spent.
                if (md_cnt != '0) begin
                    md_cnt_d = md_cnt - 1'b1;
                end
                if (!cache_ready) begin
                    state_d   = MISS;
                    md_hold_d = (md_cnt != '0);
                end else if (md_cnt == '0) begin
                    state_d = RUN;
                end
            end
            MISS: begin
                if (cache_ready) begin
                    state_d   = md_hold ? MD_BUSY : RUN;
                    md_hold_d = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= INIT;
            md_cnt  <= '0;
            md_hold <= 1'b0;
            out_q   <= OUT_INIT;
        end else begin
            state   <= state_d;
            md_cnt  <= md_cnt_d;
            md_hold <= md_hold_d;
            out_q   <= state_out(state_d);
        end
    end

    assign {pc_we, ifid_we, ifid_flush, idex_hit, idex_bubble} = out_q;

`ifdef STALL_CNT_EN
    logic [STALL_CNT_W-1:0] scnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scnt <= '0;
        end else if (!out_q[4] && state != INIT && scnt != '1) begin
            scnt <= scnt + 1'b1;
        end
    end

    assign stall_cnt = scnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, corner sequences
// and random stimulus against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam logic [4:0] E_INIT  = 5'b00001;
    localparam logic [4:0] E_RUN   = 5'b11010;
    localparam logic [4:0] E_LU    = 5'b00011;
    localparam logic [4:0] E_FRZ   = 5'b00000;
    localparam logic [4:0] E_FLUSH = 5'b10111;
    localparam int LAT = 4;

`ifdef STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        Clk;
    logic        Reset_n;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        idex_mem_read, muldiv_start, cache_ready, branch_taken;
    logic        pc_we, ifid_we, ifid_flush, idex_hit, idex_bubble;
    logic [15:0] stall_cnt;
    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_hit, s_idex_bubble;
    logic [3:0]  sat_cnt;

    pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .STALL_CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
        .idex_mem_read(idex_mem_read), .muldiv_start(muldiv_start),
        .cache_ready(cache_ready), .branch_taken(branch_taken),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_hit(idex_hit), .idex_bubble(idex_bubble),
        .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .STALL_CNT_W(4)) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
        .idex_mem_read(idex_mem_read), .muldiv_start(muldiv_start),
        .cache_ready(cache_ready), .branch_taken(branch_taken),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
        .idex_hit(s_idex_hit), .idex_bubble(s_idex_bubble),
        .stall_cnt(sat_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail = 0;

    // behavioural model: mode plus remaining mul/div busy cycles
    typedef enum {M_INIT, M_RUN, M_LU, M_BUSY, M_MISS, M_FLUSH} mode_e;
    mode_e mode;
    int    md_left;
    bit    md_resume;
    int    m_cnt;
    int    m_sat;

    function automatic logic [4:0] mode_out(input mode_e m);
        case (m)
            M_RUN:   return E_RUN;
            M_LU:    return E_LU;
            M_BUSY:  return E_FRZ;
            M_MISS:  return E_FRZ;
            M_FLUSH: return E_FLUSH;
            default: return E_INIT;
        endcase
    endfunction

    task automatic model_reset();
        mode = M_INIT;
        md_left = 0;
        md_resume = 1'b0;
        m_cnt = 0;
        m_sat = 0;
    endtask

    task automatic model_step();
        bit lu;
        logic [4:0] cur;
        lu = idex_mem_read && idex_rt != 0
             && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        cur = mode_out(mode);
        if (!cur[4] && mode != M_INIT) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_sat < 15) m_sat++;
        end
        case (mode)
            M_INIT: mode = M_RUN;
            M_BUSY: begin
                md_left--;
                if (!cache_ready) begin
                    mode = M_MISS;
                    md_resume = (md_left > 0);
                end else if (md_left == 0) begin
                    mode = M_RUN;
                end
            end
            M_MISS: begin
                if (cache_ready) begin
                    mode = md_resume ? M_BUSY : M_RUN;
                    md_resume = 1'b0;
                end
            end
            default: begin
                md_resume = 1'b0;
                if (!cache_ready) mode = M_MISS;
                else if (muldiv_start) begin
                    mode = M_BUSY;
                    md_left = LAT - 1;
                end
                else if (branch_taken) mode = M_FLUSH;
                else if (lu && mode != M_LU) mode = M_LU;
                else mode = M_RUN;
            end
        endcase
    endtask

    task automatic step();
        @(posedge Clk);
        if (Reset_n) model_step();
        #1;
    endtask

    task automatic check(input string nm, input logic [4:0] eo,
                         input int ec, input int es);
        logic [4:0] got;
        int ecx, esx;
        got = {pc_we, ifid_we, ifid_flush, idex_hit, idex_bubble};
        ecx = CNT_ON ? ec : 0;
        esx = CNT_ON ? es : 0;
        n_checks++;
        if (got !== eo || stall_cnt !== 16'(ecx) || sat_cnt !== 4'(esx)) begin
            n_fail++;
            $display("FAIL %s: got out=%b cnt=%0d sat=%0d, expected out=%b cnt=%0d sat=%0d",
                     nm, got, stall_cnt, sat_cnt, eo, ecx, esx);
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, mode_out(mode), m_cnt, m_sat);
    endtask

    task automatic idle();
        idex_mem_read = 1'b0;
        idex_rt = 5'd1;
        ifid_rs = 5'd2;
        ifid_rt = 5'd3;
        muldiv_start = 1'b0;
        cache_ready = 1'b1;
        branch_taken = 1'b0;
    endtask

    typedef struct {
        logic       mr;
        logic [4:0] xrt, rs, rt;
        logic       md, cr, br;
        logic [4:0] eo;
        int         ec;
    } vec_t;

    function automatic vec_t mk(logic mr, logic [4:0] xrt, logic [4:0] rs,
                                logic [4:0] rt, logic md, logic cr, logic br,
                                logic [4:0] eo, int ec);
        vec_t v;
        v.mr = mr; v.xrt = xrt; v.rs = rs; v.rt = rt;
        v.md = md; v.cr = cr; v.br = br; v.eo = eo; v.ec = ec;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        tbl[0]  = mk(1, 8, 8, 0, 0, 1, 0, E_LU,    0);
        tbl[1]  = mk(1, 8, 8, 0, 0, 1, 0, E_RUN,   1);
        tbl[2]  = mk(1, 0, 0, 0, 0, 1, 0, E_RUN,   1);
        tbl[3]  = mk(0, 1, 2, 3, 1, 1, 0, E_FRZ,   1);
        tbl[4]  = mk(0, 1, 2, 3, 1, 1, 0, E_FRZ,   2);
        tbl[5]  = mk(0, 1, 2, 3, 1, 1, 0, E_FRZ,   3);
        tbl[6]  = mk(0, 1, 2, 3, 0, 1, 0, E_RUN,   4);
        tbl[7]  = mk(1, 8, 8, 0, 0, 1, 1, E_FLUSH, 4);
        tbl[8]  = mk(0, 1, 2, 3, 0, 1, 0, E_RUN,   4);
        tbl[9]  = mk(0, 1, 2, 3, 0, 0, 0, E_FRZ,   4);
        tbl[10] = mk(0, 1, 2, 3, 0, 1, 0, E_RUN,   5);
        tbl[11] = mk(0, 1, 2, 3, 0, 1, 1, E_FLUSH, 5);
        tbl[12] = mk(1, 9, 0, 9, 0, 1, 0, E_LU,    5);
        tbl[13] = mk(0, 1, 2, 3, 0, 1, 0, E_RUN,   6);
        tbl[14] = mk(1, 9, 3, 4, 0, 1, 0, E_RUN,   6);
        tbl[15] = mk(0, 1, 2, 3, 1, 0, 0, E_FRZ,   6);
        tbl[16] = mk(0, 1, 2, 3, 0, 1, 0, E_RUN,   7);

        idle();
        Reset_n = 1'b0;
        model_reset();
        step();
        step();
        check("reset_state", E_INIT, 0, 0);
        Reset_n = 1'b1;
        step();
        check("reset_release", E_RUN, 0, 0);

        for (int i = 0; i < 17; i++) begin
            idex_mem_read = tbl[i].mr;
            idex_rt = tbl[i].xrt;
            ifid_rs = tbl[i].rs;
            ifid_rt = tbl[i].rt;
            muldiv_start = tbl[i].md;
            cache_ready = tbl[i].cr;
            branch_taken = tbl[i].br;
            step();
            check($sformatf("vec%0d", i), tbl[i].eo, tbl[i].ec,
                  tbl[i].ec > 15 ? 15 : tbl[i].ec);
        end

        // mul/div interrupted by a 5-cycle miss in its second busy cycle
        begin
            int frozen;
            logic [4:0] exp_seq[9];
            logic       cr_seq[9];
            exp_seq = '{E_FRZ, E_FRZ, E_FRZ, E_FRZ, E_FRZ,
                        E_FRZ, E_FRZ, E_FRZ, E_RUN};
            cr_seq  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b1, 1'b1};
            frozen = 0;
            idle();
            muldiv_start = 1'b1;
            for (int i = 0; i < 9; i++) begin
                cache_ready = cr_seq[i];
                step();
                check($sformatf("md_miss%0d", i), exp_seq[i], m_cnt, m_sat);
                if ({pc_we, idex_hit} == 2'b00) frozen++;
            end
            muldiv_start = 1'b0;
            n_checks++;
            if (frozen != 8) begin
                n_fail++;
                $display("FAIL md_miss_frozen: got %0d cycles, expected 8", frozen);
            end
        end

        // asynchronous reset asserted mid-RUN
        idle();
        step();
        check("pre_reset_run", E_RUN, m_cnt, m_sat);
        #3;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", E_INIT, 0, 0);
        step();
        check("reset_held", E_INIT, 0, 0);
        #3;
        Reset_n = 1'b1;
        step();
        check("run_after_reset", E_RUN, 0, 0);

        // long miss drives the narrow counter into saturation
        cache_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_model($sformatf("long_miss%0d", i));
        end
        n_checks++;
        if (sat_cnt !== (CNT_ON ? 4'd15 : 4'd0)) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d, expected %0d",
                     sat_cnt, CNT_ON ? 15 : 0);
        end
        cache_ready = 1'b1;
        step();
        check_model("miss_exit");

        for (int i = 0; i < 1500; i++) begin
            idex_mem_read = 1'($urandom_range(0, 1));
            idex_rt = 5'($urandom_range(0, 3));
            ifid_rs = 5'($urandom_range(0, 3));
            ifid_rt = 5'($urandom_range(0, 3));
            muldiv_start = ($urandom_range(0, 9) == 0);
            cache_ready = ($urandom_range(0, 7) != 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            step();
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
